// File: rtl/framebuffer_with_clear.sv
// framebuffer_with_clear
//   Single-clock simple-dual-port frame store (one write port, one read port)
//   with a hardware clear sweep. A clear request zeroes one location per clock,
//   starting at address 0, and rst_busy stays high until the last stored pixel
//   has been written.
//
//   Optional build macro: FRAMEBUFFER_ADDR_GUARD_EN
//     defined   : array holds exactly DEPTH pixels; writes at or above DEPTH are
//                 dropped and reads at or above DEPTH return 0.
//     undefined : array holds 2**ADDR_WIDTH pixels with no range check; the
//                 locations above DEPTH-1 are ordinary storage that the clear
//                 sweep never touches.
//
//   States:
//     ST_IDLE  | no clear in progress, user writes accepted
//     ST_CLEAR | sweep running, clr_addr is the next location to zero

module framebuffer_with_clear #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int SCALING_FACTOR = 1,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_req,
  input  logic                  en_wr,
  input  logic                  wrea,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rst_busy
);

  // Stored frame size after pixel replication is removed.
  localparam int DEPTH = (SCALING_FACTOR > 0)
                         ? (FRAME_WIDTH / SCALING_FACTOR) * (FRAME_HEIGHT / SCALING_FACTOR)
                         : 0;

`ifdef FRAMEBUFFER_ADDR_GUARD_EN
  localparam int MEM_DEPTH = DEPTH;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH+1)'(DEPTH);
`else
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
`endif

  // Last location touched by the sweep; reaching it ends the clear.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Reject geometries that cannot be stored or swept.
  if (SCALING_FACTOR < 1) begin : g_err_scale
    $error("framebuffer_with_clear: SCALING_FACTOR must be at least 1");
  end
  if ((SCALING_FACTOR >= 1) &&
      (((FRAME_WIDTH % SCALING_FACTOR) != 0) || ((FRAME_HEIGHT % SCALING_FACTOR) != 0))) begin : g_err_div
    $error("framebuffer_with_clear: SCALING_FACTOR must divide both frame dimensions");
  end
  if (longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_err_addr
    $error("framebuffer_with_clear: frame does not fit in ADDR_WIDTH address space");
  end
  if (DEPTH < 2) begin : g_err_small
    $error("framebuffer_with_clear: frame must hold at least two pixels");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Declaration initialisers give the power-up values (all zero, idle).
  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1] = '{default: '0};

  state_t                state_q    = ST_IDLE;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_addr   = '0;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
  logic                  busy_q     = 1'b0;
  logic                  busy_d;
  logic [DATA_WIDTH-1:0] dout_q     = '0;

  // Single physical write port, shared by the sweep and the user.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  user_wr;

`ifdef FRAMEBUFFER_ADDR_GUARD_EN
  assign wr_in_range = ({1'b0, addr_wr} < DEPTH_CMP);
  assign rd_in_range = ({1'b0, addr_rd} < DEPTH_CMP);
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  // A user write needs both enables, a legal address and no clear activity.
  assign user_wr = en_wr & wrea & wr_in_range & ~busy_q & ~rst_req;

  // Next-state logic and write-port arbitration; the clear always wins.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_wr;
    mem_wdata  = din;

    if (rst_req) begin
      // Request edge clears address 0 itself; the sweep resumes at 1.
      state_d    = ST_CLEAR;
      clr_addr_d = ADDR_WIDTH'(1);
      busy_d     = 1'b1;
      mem_we     = 1'b1;
      mem_waddr  = '0;
      mem_wdata  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (user_wr) begin
            mem_we = 1'b1;
          end
        end
        ST_CLEAR: begin
          mem_we     = 1'b1;
          mem_waddr  = clr_addr;
          mem_wdata  = '0;
          clr_addr_d = clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Clear FSM state, sweep counter and busy flag; rst_req restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst_req) begin
      state_q  <= ST_CLEAR;
      clr_addr <= ADDR_WIDTH'(1);
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      clr_addr <= clr_addr_d;
      busy_q   <= busy_d;
    end
  end

  // Frame array write port (no reset on the array; the sweep does that).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port; holds when disabled, forced to 0 by a clear request.
  always_ff @(posedge clk) begin
    if (rst_req) begin
      dout_q <= '0;
    end else if (en_rd) begin
      dout_q <= rd_in_range ? mem[addr_rd] : '0;
    end
  end

  assign dout     = dout_q;
  assign rst_busy = busy_q;

endmodule

// File: tb/tb_framebuffer_with_clear.sv
// Self-checking bench for framebuffer_with_clear on a 4x3 frame (DEPTH=12).
// Expected read data is pushed to a queue when a read is issued and compared
// when the registered result appears one edge later.

module tb_framebuffer_with_clear;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst_req;
  logic          en_wr;
  logic          wrea;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] din;
  logic          en_rd;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] dout;
  logic          rst_busy;

  logic [DW-1:0] model [0:15];
  logic [DW-1:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  framebuffer_with_clear #(
    .FRAME_WIDTH    (4),
    .FRAME_HEIGHT   (3),
    .SCALING_FACTOR (1),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk      (clk),
    .rst_req  (rst_req),
    .en_wr    (en_wr),
    .wrea     (wrea),
    .addr_wr  (addr_wr),
    .din      (din),
    .en_rd    (en_rd),
    .addr_rd  (addr_rd),
    .dout     (dout),
    .rst_busy (rst_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    rst_req = 1'b0;
    en_wr   = 1'b0;
    wrea    = 1'b0;
    addr_wr = '0;
    din     = '0;
    en_rd   = 1'b0;
    addr_rd = '0;
  endtask

  task automatic rd(input int a);
    en_rd   = 1'b1;
    addr_rd = AW'(a);
    exp_q.push_back(model[a]);
  endtask

  task automatic rd_exp(input int a, input logic [DW-1:0] e);
    en_rd   = 1'b1;
    addr_rd = AW'(a);
    exp_q.push_back(e);
  endtask

  task automatic wr(input int a, input int d);
    en_wr   = 1'b1;
    wrea    = 1'b1;
    addr_wr = AW'(a);
    din     = DW'(d);
  endtask

  // One clock; pops and checks the scoreboard if a read was issued.
  task automatic step();
    logic rd_now;
    rd_now = en_rd;
    @(posedge clk);
    #1;
    if (rd_now) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      rd(i);
      step();
    end
    set_idle();
    step();
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      wr(i, base + i);
      step();
      model[i] = DW'(base + i);
    end
    set_idle();
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) model[i] = '0;
    set_idle();
    @(negedge clk);

    // Power-up clear: busy must last exactly 11 more edges after R.
    rst_req = 1'b1;
    step();
    check("busy_after_R0", 32'(rst_busy), 32'd1);
    check("dout_after_R0", 32'(dout), 32'd0);
    set_idle();
    cnt = 0;
    while (rst_busy && cnt < 40) begin
      step();
      cnt++;
    end
    check("init_clear_len", 32'(cnt), 32'd11);
    clear_model();

    // Fill and readback.
    fill(0);
    read_all();
    set_idle();
    step();
    check("dout_hold", 32'(dout), 32'd11);

    // Same-edge read and write: old value first, new value after.
    set_idle();
    wr(5, 8'h99);
    rd(5);
    step();
    model[5] = 8'h99;
    set_idle();
    rd(5);
    step();

    // Strobe gating: either enable low drops the write.
    set_idle();
    en_wr = 1'b1; wrea = 1'b0; addr_wr = 4'd3; din = 8'h55;
    step();
    set_idle();
    en_wr = 1'b0; wrea = 1'b1; addr_wr = 4'd4; din = 8'h66;
    step();
    set_idle();
    rd(3);
    step();
    set_idle();
    rd(4);
    step();

    // Out-of-range address 12.
    set_idle();
    wr(12, 8'h77);
    step();
`ifndef FRAMEBUFFER_ADDR_GUARD_EN
    model[12] = 8'h77;
`endif
    set_idle();
    rd(12);
    step();
    set_idle();
    step();

    // Clear timing, reads during sweep, blocked write at addr 11.
    set_idle();
    rst_req = 1'b1;
    rd_exp(2, 8'h00);
    step();
    check("busy_after_R", 32'(rst_busy), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      set_idle();
      if (k == 2) rd_exp(11, 8'd11);
      if (k == 3) rd_exp(1, 8'h00);
      if (k == 4) wr(11, 8'hAA);
      step();
      check($sformatf("busy_R+%0d", k), 32'(rst_busy), (k < 11) ? 32'd1 : 32'd0);
    end
    clear_model();
    read_all();
`ifndef FRAMEBUFFER_ADDR_GUARD_EN
    set_idle();
    rd(12);
    step();
    set_idle();
    step();
`endif

    // Mid-sweep restart at R+5.
    fill(8'h10);
    set_idle();
    rst_req = 1'b1;
    step();
    set_idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("rs_busy_R+%0d", k), 32'(rst_busy), 32'd1);
    end
    rst_req = 1'b1;
    step();
    check("rs_busy_R+5", 32'(rst_busy), 32'd1);
    set_idle();
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("rs_busy_R2+%0d", k), 32'(rst_busy), (k < 11) ? 32'd1 : 32'd0);
    end
    clear_model();
    read_all();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
